// File: rtl/serial_slave_port_burst.sv
// serial_slave_port_burst
//   Serial bus slave port with incrementing bursts. The master shifts in a header
//   (mode on the first beat, then address, then burst length) LSB-first, LANES bits
//   per beat. For writes it then shifts in len+1 data words. Reads return len+1
//   words as svalid beats. Words go to or come from a synchronous slave memory
//   with MEM_RD_LAT cycles of read latency.
//
//   Optional build macro SPORT_RD_PREFETCH_EN: during a read burst, the next
//   word's read is issued in the first beat cycle of the current word. The
//   returned data is kept in a second word buffer, which hides the memory
//   latency between words.
//
// Ports
//   clk, rstn            clock, synchronous active-low reset
//   swdata, smode        header/write-data beat and access mode (1 = write)
//   mvalid / sready      beat handshake; a beat moves when both are high
//   srdata, svalid       read-data beat to the master
//   smemwen, smemren     single-cycle memory write/read strobes
//   smemaddr, smemwdata  memory address and write data; hold between accesses
//   smemrdata            memory read data, valid MEM_RD_LAT cycles after smemren
module serial_slave_port_burst #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 1,
  parameter int unsigned LEN_WIDTH  = 4,
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] smemrdata,
  output logic                  smemwen,
  output logic                  smemren,
  output logic [ADDR_WIDTH-1:0] smemaddr,
  output logic [DATA_WIDTH-1:0] smemwdata,
  input  logic [LANES-1:0]      swdata,
  output logic [LANES-1:0]      srdata,
  input  logic                  smode,
  input  logic                  mvalid,
  output logic                  svalid,
  output logic                  sready
);

  localparam int unsigned AB   = ADDR_WIDTH / LANES;
  localparam int unsigned LB   = LEN_WIDTH / LANES;
  localparam int unsigned DB   = DATA_WIDTH / LANES;
  localparam int unsigned MAXB = (AB > LB) ? ((AB > DB) ? AB : DB) : ((LB > DB) ? LB : DB);
  localparam int unsigned BW   = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam int unsigned TW   = $clog2(MEM_RD_LAT + 1);

  localparam logic [BW-1:0] ALAST = BW'(AB - 1);
  localparam logic [BW-1:0] LLAST = BW'(LB - 1);
  localparam logic [BW-1:0] DLAST = BW'(DB - 1);
  localparam logic [TW-1:0] LAT   = TW'(MEM_RD_LAT);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ADDR  = 3'd1;
  localparam logic [2:0] LEN   = 3'd2;
  localparam logic [2:0] WDATA = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] RREQ  = 3'd5;
  localparam logic [2:0] RWAIT = 3'd6;
  localparam logic [2:0] RDATA = 3'd7;

  logic [2:0]            state_q, state_d;
  logic                  mode_q, mode_d;
  logic [BW-1:0]         beat_q, beat_d;
  // addr_q always holds the address of the next access to be issued
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  // wcnt_q collects the length field, then counts words left after the current one
  logic [LEN_WIDTH-1:0]  wcnt_q, wcnt_d;
  // data_q shifts write beats in at the top and read beats out at the bottom
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [TW-1:0]         lat_q, lat_d;
  logic [ADDR_WIDTH-1:0] smemaddr_q, smemaddr_d;
  logic [DATA_WIDTH-1:0] smemwdata_q, smemwdata_d;
`ifdef SPORT_RD_PREFETCH_EN
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  bufv_q, bufv_d;
`endif

  logic                  accept;
  logic                  pf_issue;
  logic                  access_next;
  logic [ADDR_WIDTH-1:0] addr_sh;
  logic [LEN_WIDTH-1:0]  wcnt_sh;
  logic [DATA_WIDTH-1:0] data_sh;

  assign sready = (state_q == IDLE) || (state_q == ADDR) || (state_q == LEN) ||
                  (state_q == WDATA);
  assign accept = mvalid && sready;

  assign addr_sh = (addr_q >> LANES) | (ADDR_WIDTH'(swdata) << (ADDR_WIDTH - LANES));
  assign wcnt_sh = (wcnt_q >> LANES) | (LEN_WIDTH'(swdata) << (LEN_WIDTH - LANES));
  assign data_sh = (data_q >> LANES) | (DATA_WIDTH'(swdata) << (DATA_WIDTH - LANES));

`ifdef SPORT_RD_PREFETCH_EN
  assign pf_issue = (state_q == RDATA) && (beat_q == '0) && (wcnt_q != '0);
`else
  assign pf_issue = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    data_d  = data_q;
    lat_d   = lat_q;
`ifdef SPORT_RD_PREFETCH_EN
    buf_d   = buf_q;
    bufv_d  = bufv_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          mode_d = smode;
          addr_d = addr_sh;
          if (AB == 1) begin
            state_d = LEN;
            beat_d  = '0;
          end else begin
            state_d = ADDR;
            beat_d  = BW'(1);
          end
        end
      end
      ADDR: begin
        if (accept) begin
          addr_d = addr_sh;
          if (beat_q == ALAST) begin
            state_d = LEN;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      LEN: begin
        if (accept) begin
          wcnt_d = wcnt_sh;
          if (beat_q == LLAST) begin
            state_d = mode_q ? WDATA : RREQ;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      WDATA: begin
        if (accept) begin
          data_d = data_sh;
          if (beat_q == DLAST) begin
            state_d = WRITE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      WRITE: begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        if (wcnt_q != '0) begin
          wcnt_d  = wcnt_q - LEN_WIDTH'(1);
          state_d = WDATA;
        end else begin
          state_d = IDLE;
        end
      end
      RREQ: begin
        addr_d  = addr_q + ADDR_WIDTH'(1);
        lat_d   = LAT;
        state_d = RWAIT;
      end
      RWAIT: begin
        lat_d = lat_q - TW'(1);
        if (lat_q == TW'(1)) begin
          data_d  = smemrdata;
          state_d = RDATA;
          beat_d  = '0;
        end
      end
      default: begin  // RDATA
        data_d = data_q >> LANES;
        beat_d = beat_q + BW'(1);
`ifdef SPORT_RD_PREFETCH_EN
        if (lat_q != '0) begin
          lat_d = lat_q - TW'(1);
          if (lat_q == TW'(1)) begin
            buf_d  = smemrdata;
            bufv_d = 1'b1;
          end
        end
        if (pf_issue) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          lat_d  = LAT;
        end
`endif
        if (beat_q == DLAST) begin
          beat_d = '0;
          if (wcnt_q == '0) begin
            state_d = IDLE;
          end else begin
            wcnt_d = wcnt_q - LEN_WIDTH'(1);
`ifdef SPORT_RD_PREFETCH_EN
            // Continue straight into the next word if its data is already here
            // or arrives this cycle; otherwise wait out the remaining latency.
            if (bufv_q) begin
              data_d = buf_q;
              bufv_d = 1'b0;
            end else if (lat_q == TW'(1)) begin
              data_d = smemrdata;
              bufv_d = 1'b0;
            end else begin
              state_d = RWAIT;
            end
`else
            state_d = RREQ;
`endif
          end
        end
      end
    endcase
  end

  // Address/data registers load only in the cycle before an access so they hold
  // their last value while the next header is being collected.
`ifdef SPORT_RD_PREFETCH_EN
  assign access_next = (state_d == WRITE) || (state_d == RREQ) ||
                       ((state_d == RDATA) && (beat_d == '0) && (wcnt_d != '0));
`else
  assign access_next = (state_d == WRITE) || (state_d == RREQ);
`endif
  assign smemaddr_d  = access_next ? addr_d : smemaddr_q;
  assign smemwdata_d = (state_d == WRITE) ? data_d : smemwdata_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      beat_q      <= '0;
      addr_q      <= '0;
      wcnt_q      <= '0;
      data_q      <= '0;
      lat_q       <= '0;
      smemaddr_q  <= '0;
      smemwdata_q <= '0;
`ifdef SPORT_RD_PREFETCH_EN
      buf_q       <= '0;
      bufv_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      beat_q      <= beat_d;
      addr_q      <= addr_d;
      wcnt_q      <= wcnt_d;
      data_q      <= data_d;
      lat_q       <= lat_d;
      smemaddr_q  <= smemaddr_d;
      smemwdata_q <= smemwdata_d;
`ifdef SPORT_RD_PREFETCH_EN
      buf_q       <= buf_d;
      bufv_q      <= bufv_d;
`endif
    end
  end

  assign smemwen   = (state_q == WRITE);
  assign smemren   = (state_q == RREQ) || pf_issue;
  assign smemaddr  = smemaddr_q;
  assign smemwdata = smemwdata_q;
  assign svalid    = (state_q == RDATA);
  assign srdata    = svalid ? data_q[LANES-1:0] : '0;

endmodule

// File: tb/tb_serial_slave_port_burst.sv
module tb_serial_slave_port_burst;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;
  localparam int unsigned LN = 2;
  localparam int unsigned LW = 4;
  localparam int unsigned RL = 1;

`ifdef SPORT_RD_PREFETCH_EN
  localparam int BEAT_GAP = 1;
  localparam int REQ_GAP  = 2;
`else
  localparam int BEAT_GAP = 3;
  localparam int REQ_GAP  = 6;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] smemrdata;
  logic          smemwen, smemren, svalid, sready;
  logic [AW-1:0] smemaddr;
  logic [DW-1:0] smemwdata;
  logic [LN-1:0] swdata = '0;
  logic [LN-1:0] srdata;
  logic          smode = 1'b0;
  logic          mvalid = 1'b0;

  always #5 clk = ~clk;

  serial_slave_port_burst #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .LANES      (LN),
    .LEN_WIDTH  (LW),
    .MEM_RD_LAT (RL)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .smemrdata (smemrdata),
    .smemwen   (smemwen),
    .smemren   (smemren),
    .smemaddr  (smemaddr),
    .smemwdata (smemwdata),
    .swdata    (swdata),
    .srdata    (srdata),
    .smode     (smode),
    .mvalid    (mvalid),
    .svalid    (svalid),
    .sready    (sready)
  );

  // Memory model with one cycle of read latency
  logic [DW-1:0] mem [4096];
  logic [DW-1:0] rdq = '0;
  assign smemrdata = rdq;
  always @(posedge clk) begin
    if (smemren) rdq <= mem[smemaddr];
    if (smemwen) mem[smemaddr] <= smemwdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Activity log, sampled away from the active edge
  int            nwr = 0, nrd = 0, nbeat = 0, nboth = 0;
  logic [AW-1:0] wr_addr [64];
  logic [DW-1:0] wr_data [64];
  int            wr_cyc  [64];
  logic [AW-1:0] rd_addr [64];
  int            rd_cyc  [64];
  logic [LN-1:0] bt      [128];
  int            bt_cyc  [128];

  always @(negedge clk) begin
    if (smemwen && smemren) nboth++;
    if (smemwen && nwr < 64) begin
      wr_addr[nwr] = smemaddr; wr_data[nwr] = smemwdata; wr_cyc[nwr] = cyc; nwr++;
    end
    if (smemren && nrd < 64) begin
      rd_addr[nrd] = smemaddr; rd_cyc[nrd] = cyc; nrd++;
    end
    if (svalid && nbeat < 128) begin
      bt[nbeat] = srdata; bt_cyc[nbeat] = cyc; nbeat++;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is taken.
  task automatic put_beat(input logic [1:0] b);
    int n;
    n = 0;
    swdata = b;
    mvalid = 1'b1;
    while (!sready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("beat_accept", 32'(sready), 32'd1);
    @(negedge clk);
  endtask

  task automatic send_field(input logic [31:0] v, input int nb);
    for (int i = 0; i < nb; i++) put_beat(v[2*i +: 2]);
  endtask

  task automatic send_hdr(input logic m, input logic [11:0] a, input logic [3:0] l);
    smode = m;
    send_field(32'(a), 6);
    send_field(32'(l), 2);
  endtask

  task automatic idle_bus();
    mvalid = 1'b0;
    swdata = '0;
  endtask

  int w0, r0, b0, t0;
  logic [1:0] exp6 [8];

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[12'h123] = 8'hA7;
    mem[12'h010] = 8'hC4;
    mem[12'h011] = 8'h39;
    exp6[0] = 2'b00; exp6[1] = 2'b01; exp6[2] = 2'b00; exp6[3] = 2'b11;
    exp6[4] = 2'b01; exp6[5] = 2'b10; exp6[6] = 2'b11; exp6[7] = 2'b00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sready", 32'(sready), 32'd1);
    check("rst_wen", 32'(smemwen), 32'd0);
    check("rst_ren", 32'(smemren), 32'd0);
    check("rst_svalid", 32'(svalid), 32'd0);
    check("rst_addr", 32'(smemaddr), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("rel_sready", 32'(sready), 32'd1);

    // 1: single write
    w0 = nwr; t0 = cyc;
    send_hdr(1'b1, 12'h0A5, 4'd0);
    send_field(32'h3C, 4);
    idle_bus();
    @(negedge clk);
    check("t1_sready", 32'(sready), 32'd1);
    check("t1_wen_low", 32'(smemwen), 32'd0);
    repeat (3) @(negedge clk);
    check("t1_nwr", 32'(nwr - w0), 32'd1);
    check("t1_addr", 32'(wr_addr[w0]), 32'h0A5);
    check("t1_data", 32'(wr_data[w0]), 32'h3C);
    check("t1_lat", 32'(wr_cyc[w0] - t0), 32'd12);

    // 2: write burst wrapping the address
    w0 = nwr; r0 = nrd;
    send_hdr(1'b1, 12'hFFF, 4'd2);
    send_field(32'h11, 4);
    send_field(32'h22, 4);
    send_field(32'h33, 4);
    idle_bus();
    repeat (4) @(negedge clk);
    check("t2_nwr", 32'(nwr - w0), 32'd3);
    check("t2_a0", 32'(wr_addr[w0]), 32'hFFF);
    check("t2_d0", 32'(wr_data[w0]), 32'h11);
    check("t2_a1", 32'(wr_addr[w0+1]), 32'h000);
    check("t2_d1", 32'(wr_data[w0+1]), 32'h22);
    check("t2_a2", 32'(wr_addr[w0+2]), 32'h001);
    check("t2_d2", 32'(wr_data[w0+2]), 32'h33);
    check("t2_nrd", 32'(nrd - r0), 32'd0);
    check("t2_hold_addr", 32'(smemaddr), 32'h001);
    check("t2_hold_data", 32'(smemwdata), 32'h33);

    // 3: single read
    w0 = nwr; r0 = nrd; b0 = nbeat; t0 = cyc;
    send_hdr(1'b0, 12'h123, 4'd0);
    idle_bus();
    for (int i = 0; i < 30 && (nbeat - b0) < 4; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("t3_nrd", 32'(nrd - r0), 32'd1);
    check("t3_raddr", 32'(rd_addr[r0]), 32'h123);
    check("t3_req_lat", 32'(rd_cyc[r0] - t0), 32'd8);
    check("t3_nbeat", 32'(nbeat - b0), 32'd4);
    check("t3_first", 32'(bt_cyc[b0] - rd_cyc[r0]), 32'd2);
    check("t3_span", 32'(bt_cyc[b0+3] - bt_cyc[b0]), 32'd3);
    check("t3_b0", 32'(bt[b0]), 32'd3);
    check("t3_b1", 32'(bt[b0+1]), 32'd1);
    check("t3_b2", 32'(bt[b0+2]), 32'd2);
    check("t3_b3", 32'(bt[b0+3]), 32'd2);
    check("t3_nwr", 32'(nwr - w0), 32'd0);
    check("t3_hold_addr", 32'(smemaddr), 32'h123);
    check("t3_srdata_idle", 32'(srdata), 32'd0);

    // 4: write of test 1 with a 3-cycle mvalid stall inside the address
    w0 = nwr; t0 = cyc;
    smode = 1'b1;
    send_field(32'h0A5, 3);
    mvalid = 1'b0;
    swdata = 2'b11;
    repeat (3) @(negedge clk);
    send_field(32'h0A5 >> 6, 3);
    send_field(32'h0, 2);
    send_field(32'h3C, 4);
    idle_bus();
    repeat (3) @(negedge clk);
    check("t4_nwr", 32'(nwr - w0), 32'd1);
    check("t4_addr", 32'(wr_addr[w0]), 32'h0A5);
    check("t4_data", 32'(wr_data[w0]), 32'h3C);
    check("t4_lat", 32'(wr_cyc[w0] - t0), 32'd15);

    // 5: reset in the middle of a write burst
    w0 = nwr;
    send_hdr(1'b1, 12'hFFF, 4'd2);
    send_field(32'h11, 4);
    send_field(32'h22, 2);
    idle_bus();
    rstn = 1'b0;
    @(negedge clk);
    check("t5_wen", 32'(smemwen), 32'd0);
    check("t5_ren", 32'(smemren), 32'd0);
    check("t5_svalid", 32'(svalid), 32'd0);
    check("t5_srdata", 32'(srdata), 32'd0);
    check("t5_addr", 32'(smemaddr), 32'd0);
    check("t5_wdata", 32'(smemwdata), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("t5_sready", 32'(sready), 32'd1);
    repeat (4) @(negedge clk);
    check("t5_nwr", 32'(nwr - w0), 32'd1);
    w0 = nwr;
    send_hdr(1'b1, 12'h2B4, 4'd0);
    send_field(32'hE1, 4);
    idle_bus();
    repeat (3) @(negedge clk);
    check("t5_after_nwr", 32'(nwr - w0), 32'd1);
    check("t5_after_addr", 32'(wr_addr[w0]), 32'h2B4);
    check("t5_after_data", 32'(wr_data[w0]), 32'hE1);

    // 6: read burst of two words
    r0 = nrd; b0 = nbeat;
    send_hdr(1'b0, 12'h010, 4'd1);
    idle_bus();
    for (int i = 0; i < 40 && (nbeat - b0) < 8; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check("t6_nbeat", 32'(nbeat - b0), 32'd8);
    check("t6_nrd", 32'(nrd - r0), 32'd2);
    check("t6_ra0", 32'(rd_addr[r0]), 32'h010);
    check("t6_ra1", 32'(rd_addr[r0+1]), 32'h011);
    check("t6_req_gap", 32'(rd_cyc[r0+1] - rd_cyc[r0]), 32'(REQ_GAP));
    check("t6_w0_span", 32'(bt_cyc[b0+3] - bt_cyc[b0]), 32'd3);
    check("t6_w1_span", 32'(bt_cyc[b0+7] - bt_cyc[b0+4]), 32'd3);
    check("t6_word_gap", 32'(bt_cyc[b0+4] - bt_cyc[b0+3]), 32'(BEAT_GAP));
    for (int i = 0; i < 8; i++) check($sformatf("t6_beat%0d", i), 32'(bt[b0+i]), 32'(exp6[i]));

    check("never_both", 32'(nboth), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
